// File: rtl/system_load_buffer_pkg.sv
// Shared types for the load/store buffer stage: ld_code values, widths, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package system_types;

  localparam int REG_W  = 5;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  // Destination-write source selected by decode
  localparam logic [1:0] LD_NONE = 2'b00;
  localparam logic [1:0] LD_ALU  = 2'b01;
  localparam logic [1:0] LD_MEM  = 2'b10;
  localparam logic [1:0] LD_IMM  = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    WAIT_LD = 2'b01,
    WAIT_ST = 2'b10,
    WB      = 2'b11
  } lsb_state_t;

  // True for codes whose register write happens downstream in the same cycle
  function automatic logic is_direct_write(input logic [1:0] code);
    return (code == LD_ALU) || (code == LD_IMM);
  endfunction

endpackage

// File: rtl/system_load_buffer_hazard.sv
// Stall decision for the load buffer: wait states plus read-after-load and write-collision hazards.
// Latency: purely combinational.
// Backpressure: stall_o is the backpressure itself; it holds decode while asserted.
module load_hazard_check
  import system_types::*;
#(
  parameter int RW = 5
) (
  input  lsb_state_t      state_i,
  input  logic [RW-1:0]   buf_last_i,
  input  logic [RW-1:0]   rs_a_i,
  input  logic [RW-1:0]   rs_b_i,
  input  logic [RW-1:0]   to_reg_i,
  input  logic [1:0]      ld_code_i,
  input  logic            op_valid_i,
  output logic            stall_o
);

  logic busy;
  logic in_wb;
  logic raw_hit;
  logic wr_hit;

  // Decode hazards against the register being written back this cycle
  always_comb begin
    busy    = (state_i == WAIT_LD) || (state_i == WAIT_ST);
    in_wb   = op_valid_i && (state_i == WB);
    // r0 never carries a buffered write, so reading it is never a hazard
    raw_hit = in_wb && (buf_last_i != '0) &&
              ((rs_a_i == buf_last_i) || (rs_b_i == buf_last_i));
    // The buffered write owns the port this cycle; a same-register direct write waits
    wr_hit  = in_wb && is_direct_write(ld_code_i) && (to_reg_i == buf_last_i);
    stall_o = busy || raw_hit || wr_hit;
  end

endmodule

// File: rtl/system_load_buffer.sv
// Deferred load/store stage: issues one data-memory request at a time, returns load data as a one-cycle (buf_last, buf_data) pair.
// Latency: request one cycle after acceptance; load writeback one cycle after mem_ack (minimum 2 cycles).
// Backpressure: stall_o holds decode while a request is outstanding or a writeback hazard exists; mem_req holds until mem_ack.
module system_load_buffer
  import system_types::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              system1000,
  input  logic              system1000_rstn,
  input  logic              op_valid,
  input  logic [1:0]        ld_code,
  input  logic              st_en,
  input  logic [REG_W-1:0]  to_reg,
  input  logic [REG_W-1:0]  rs_a,
  input  logic [REG_W-1:0]  rs_b,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] st_data_i,
  output logic              stall_o,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [REG_W-1:0]  buf_last,
  output logic [DATA_W-1:0] buf_data
);

  lsb_state_t        state_q, state_d;
  logic [REG_W-1:0]  pend_reg_q, pend_reg_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [REG_W-1:0]  buf_last_q, buf_last_d;
  logic [DATA_W-1:0] buf_data_q, buf_data_d;

  logic accept;
  logic acc_load;
  logic acc_store;

  load_hazard_check #(
    .RW (REG_W)
  ) u_hazard (
    .state_i    (state_q),
    .buf_last_i (buf_last_q),
    .rs_a_i     (rs_a),
    .rs_b_i     (rs_b),
    .to_reg_i   (to_reg),
    .ld_code_i  (ld_code),
    .op_valid_i (op_valid),
    .stall_o    (stall_o)
  );

  // Acceptance only when no request is outstanding; direct writes need no local action
  always_comb begin
    accept    = op_valid && !stall_o && ((state_q == IDLE) || (state_q == WB));
    acc_load  = accept && (ld_code == LD_MEM);
    acc_store = accept && st_en && (ld_code != LD_MEM);
  end

  // Next-state and datapath capture
  always_comb begin
    state_d    = state_q;
    pend_reg_d = pend_reg_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    buf_last_d = '0;          // writeback lasts exactly one cycle
    buf_data_d = buf_data_q;

    unique case (state_q)
      IDLE, WB: begin
        // mem_ack is meaningless here and deliberately ignored
        if (acc_load) begin
          pend_reg_d = to_reg;
          addr_d     = mem_addr_i;
          state_d    = WAIT_LD;
        end else if (acc_store) begin
          addr_d     = mem_addr_i;
          wdata_d    = st_data_i;
          state_d    = WAIT_ST;
        end else begin
          state_d    = IDLE;
        end
      end
      WAIT_LD: begin
        if (mem_ack) begin
          buf_data_d = mem_rdata;
          buf_last_d = pend_reg_q;  // r0 destination yields buf_last = 0: no write
          state_d    = WB;
        end
      end
      WAIT_ST: begin
        if (mem_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and captured-operand registers
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      state_q    <= IDLE;
      pend_reg_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      buf_last_q <= '0;
      buf_data_q <= '0;
    end else begin
      state_q    <= state_d;
      pend_reg_q <= pend_reg_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      buf_last_q <= buf_last_d;
      buf_data_q <= buf_data_d;
    end
  end

  // Request is decoded from state so an async reset drops it without a clock edge
  always_comb begin
    mem_req   = (state_q == WAIT_LD) || (state_q == WAIT_ST);
    mem_we    = (state_q == WAIT_ST);
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    buf_last  = buf_last_q;
    buf_data  = buf_data_q;
  end

endmodule

// File: tb/tb_system_load_buffer.sv
module tb_system_load_buffer;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        op_valid = 1'b0;
  logic [1:0]  ld_code = 2'b00;
  logic        st_en = 1'b0;
  logic [4:0]  to_reg = '0, rs_a = '0, rs_b = '0;
  logic [15:0] mem_addr_i = '0;
  logic [31:0] st_data_i = '0;
  logic        stall_o, mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [4:0]  buf_last;
  logic [31:0] buf_data;

  int tests = 0;
  int fails = 0;

  system_load_buffer dut (
    .system1000      (clk),
    .system1000_rstn (rstn),
    .op_valid        (op_valid),
    .ld_code         (ld_code),
    .st_en           (st_en),
    .to_reg          (to_reg),
    .rs_a            (rs_a),
    .rs_b            (rs_b),
    .mem_addr_i      (mem_addr_i),
    .st_data_i       (st_data_i),
    .stall_o         (stall_o),
    .mem_req         (mem_req),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_ack         (mem_ack),
    .mem_rdata       (mem_rdata),
    .buf_last        (buf_last),
    .buf_data        (buf_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // pend: 0 = nothing outstanding, 1 = load outstanding, 2 = store outstanding
  int          m_pend = 0;
  logic [15:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic [4:0]  m_reg = '0;
  logic        m_wb = 1'b0;   // a load completed last cycle
  logic [4:0]  m_wb_reg = '0;
  logic [31:0] m_wb_data = '0;

  function automatic logic model_stall();
    logic hz;
    hz = 1'b0;
    if (op_valid && m_wb) begin
      if (m_wb_reg != 0 && (rs_a == m_wb_reg || rs_b == m_wb_reg)) hz = 1'b1;
      if ((ld_code == 2'b01 || ld_code == 2'b11) && to_reg == m_wb_reg) hz = 1'b1;
    end
    return (m_pend != 0) || hz;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_pend = 0; m_wb = 1'b0; m_wb_reg = '0;
    end else begin
      logic acc;
      acc = op_valid && !model_stall() && (m_pend == 0);
      m_wb = 1'b0;
      m_wb_reg = '0;
      if (m_pend == 1 && mem_ack) begin
        m_wb = 1'b1; m_wb_reg = m_reg; m_wb_data = mem_rdata; m_pend = 0;
      end else if (m_pend == 2 && mem_ack) begin
        m_pend = 0;
      end
      if (acc && ld_code == 2'b10) begin
        m_pend = 1; m_addr = mem_addr_i; m_reg = to_reg;
      end else if (acc && st_en) begin
        m_pend = 2; m_addr = mem_addr_i; m_wdata = st_data_i;
      end
    end
  end

  // Compare every cycle on the falling edge
  always @(negedge clk) begin
    if (!rstn) begin
      chk("rst_stall", {31'b0, stall_o}, 0);
      chk("rst_req", {31'b0, mem_req}, 0);
      chk("rst_buf_last", {27'b0, buf_last}, 0);
    end else begin
      chk("m_stall", {31'b0, stall_o}, {31'b0, model_stall()});
      chk("m_req", {31'b0, mem_req}, (m_pend != 0) ? 1 : 0);
      chk("m_we", {31'b0, mem_we}, (m_pend == 2) ? 1 : 0);
      chk("m_buf_last", {27'b0, buf_last}, {27'b0, m_wb_reg});
      if (m_pend != 0) chk("m_addr", {16'b0, mem_addr}, {16'b0, m_addr});
      if (m_pend == 2) chk("m_wdata", mem_wdata, m_wdata);
      if (m_wb) chk("m_buf_data", buf_data, m_wb_data);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input logic ov, input logic [1:0] ld, input logic st,
                     input logic [4:0] to, input logic [4:0] ra, input logic [4:0] rb,
                     input logic [15:0] ad, input logic [31:0] wd,
                     input logic ak, input logic [31:0] rd);
    @(posedge clk);
    #1;
    op_valid = ov; ld_code = ld; st_en = st; to_reg = to; rs_a = ra; rs_b = rb;
    mem_addr_i = ad; st_data_i = wd; mem_ack = ak; mem_rdata = rd;
    #1;
  endtask

  task automatic idle(input logic ak, input logic [31:0] rd);
    cyc(1'b0, 2'b00, 1'b0, 5'd0, 5'd0, 5'd0, 16'h0, 32'h0, ak, rd);
  endtask

  task automatic load(input logic [4:0] r, input logic [15:0] ad);
    cyc(1'b1, 2'b10, 1'b0, r, 5'd0, 5'd0, ad, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    #2;
    chk("reset_stall", {31'b0, stall_o}, 0);
    chk("reset_mem_req", {31'b0, mem_req}, 0);
    chk("reset_mem_we", {31'b0, mem_we}, 0);
    chk("reset_mem_addr", {16'b0, mem_addr}, 0);
    chk("reset_mem_wdata", mem_wdata, 0);
    chk("reset_buf_last", {27'b0, buf_last}, 0);
    chk("reset_buf_data", buf_data, 0);
    @(posedge clk); #1 rstn = 1'b1;

    // Load r4 from 0x0010, ack on third request cycle
    load(5'd4, 16'h0010);
    chk("ld4_accept_stall", {31'b0, stall_o}, 0);
    idle(1'b0, 32'h0);
    chk("ld4_req1", {31'b0, mem_req}, 1);
    chk("ld4_stall1", {31'b0, stall_o}, 1);
    chk("ld4_addr", {16'b0, mem_addr}, 32'h0010);
    chk("ld4_we", {31'b0, mem_we}, 0);
    idle(1'b0, 32'h0);
    chk("ld4_req2", {31'b0, mem_req}, 1);
    idle(1'b1, 32'hDEADBEEF);
    chk("ld4_req3", {31'b0, mem_req}, 1);
    chk("ld4_stall3", {31'b0, stall_o}, 1);
    idle(1'b0, 32'h0);
    chk("ld4_wb_last", {27'b0, buf_last}, 4);
    chk("ld4_wb_data", buf_data, 32'hDEADBEEF);
    chk("ld4_wb_req", {31'b0, mem_req}, 0);
    idle(1'b0, 32'h0);
    chk("ld4_after_last", {27'b0, buf_last}, 0);

    // Store 0x12345678 to 0x0020, ack in the first request cycle
    cyc(1'b1, 2'b00, 1'b1, 5'd0, 5'd0, 5'd0, 16'h0020, 32'h12345678, 1'b0, 32'h0);
    idle(1'b1, 32'h0);
    chk("st_req", {31'b0, mem_req}, 1);
    chk("st_we", {31'b0, mem_we}, 1);
    chk("st_wdata", mem_wdata, 32'h12345678);
    chk("st_addr", {16'b0, mem_addr}, 32'h0020);
    idle(1'b0, 32'h0);
    chk("st_done_stall", {31'b0, stall_o}, 0);
    chk("st_done_req", {31'b0, mem_req}, 0);
    chk("st_buf_last", {27'b0, buf_last}, 0);
    idle(1'b1, 32'h0);  // stray ack while idle

    // Read-after-load hazard on r7
    load(5'd7, 16'h0040);
    idle(1'b1, 32'hA5A5A5A5);
    cyc(1'b1, 2'b01, 1'b0, 5'd9, 5'd7, 5'd0, 16'h0, 32'h0, 1'b0, 32'h0);
    chk("raw_wb_last", {27'b0, buf_last}, 7);
    chk("raw_stall", {31'b0, stall_o}, 1);
    cyc(1'b1, 2'b01, 1'b0, 5'd9, 5'd7, 5'd0, 16'h0, 32'h0, 1'b0, 32'h0);
    chk("raw_accept", {31'b0, stall_o}, 0);
    idle(1'b0, 32'h0);

    // Write collision on r7
    load(5'd7, 16'h0044);
    idle(1'b1, 32'h0BADF00D);
    cyc(1'b1, 2'b01, 1'b0, 5'd7, 5'd1, 5'd2, 16'h0, 32'h0, 1'b0, 32'h0);
    chk("col_stall", {31'b0, stall_o}, 1);
    chk("col_wb_data", buf_data, 32'h0BADF00D);
    cyc(1'b1, 2'b01, 1'b0, 5'd7, 5'd1, 5'd2, 16'h0, 32'h0, 1'b0, 32'h0);
    chk("col_accept", {31'b0, stall_o}, 0);
    idle(1'b0, 32'h0);

    // Back-to-back loads r3 then r5, immediate acks
    load(5'd3, 16'h0030);
    idle(1'b1, 32'h00000033);
    cyc(1'b1, 2'b10, 1'b0, 5'd5, 5'd1, 5'd2, 16'h0050, 32'h0, 1'b0, 32'h0);
    chk("b2b_last3", {27'b0, buf_last}, 3);
    chk("b2b_accept", {31'b0, stall_o}, 0);
    idle(1'b1, 32'h00000055);
    chk("b2b_req", {31'b0, mem_req}, 1);
    chk("b2b_addr", {16'b0, mem_addr}, 32'h0050);
    chk("b2b_gap", {27'b0, buf_last}, 0);
    idle(1'b0, 32'h0);
    chk("b2b_last5", {27'b0, buf_last}, 5);
    chk("b2b_data5", buf_data, 32'h00000055);
    idle(1'b0, 32'h0);

    // Async reset while waiting on a load
    load(5'd6, 16'h0060);
    idle(1'b0, 32'h0);
    chk("rstld_req", {31'b0, mem_req}, 1);
    #1 rstn = 1'b0;
    #1;
    chk("rstld_req_drop", {31'b0, mem_req}, 0);
    chk("rstld_stall", {31'b0, stall_o}, 0);
    idle(1'b0, 32'h0);
    rstn = 1'b1;
    idle(1'b1, 32'h00000066);  // late ack
    idle(1'b0, 32'h0);
    chk("rstld_last", {27'b0, buf_last}, 0);
    chk("rstld_req_after", {31'b0, mem_req}, 0);

    // Load to r0: memory read happens, no buffered write
    load(5'd0, 16'h0070);
    idle(1'b1, 32'h00000077);
    chk("r0_req", {31'b0, mem_req}, 1);
    chk("r0_addr", {16'b0, mem_addr}, 32'h0070);
    idle(1'b0, 32'h0);
    chk("r0_last", {27'b0, buf_last}, 0);
    chk("r0_req_done", {31'b0, mem_req}, 0);
    idle(1'b0, 32'h0);
    chk("r0_single_read", {31'b0, mem_req}, 0);

    idle(1'b0, 32'h0);
    idle(1'b0, 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/system_load_buffer.md
# system_load_buffer

Deferred-load and store stage between decode/execute and the register file write-enable logic. Issues data-memory requests for load (`ld_code = 2'b10`) and store operations, and holds the pipeline while a request is outstanding. Returns load data as a one-cycle `(buf_last, buf_data)` pair. The per-register output-enable blocks consume `buf_last` directly: register `r` is written when `buf_last == r`, or when `to_reg == r` and `ld_code` is `01`/`11`. Register index 0 is hardwired zero, so `buf_last == 0` means "no buffered write".

## Interface
Parameters:
- `ADDR_W`, default 16: data-memory address width.
- `DATA_W`, default 32: data word width.
- `REG_W`, default 5: register index width (32 registers).

Ports:
- `system1000`, in, 1: system clock. One clock; all state is on its rising edge.
- `system1000_rstn`, in, 1: reset, asynchronous and active-low.
- `op_valid`, in, 1: decoded instruction present this cycle.
- `ld_code`, in, 2: `00` none, `01` ALU write, `10` memory load (deferred), `11` immediate write.
- `st_en`, in, 1: instruction is a store. Mutually exclusive with `ld_code = 10`.
- `to_reg`, in, `REG_W`: destination register.
- `rs_a`, `rs_b`, in, `REG_W`: source registers of the current instruction.
- `mem_addr_i`, in, `ADDR_W`: effective address.
- `st_data_i`, in, `DATA_W`: store data.
- `stall_o`, out, 1: freeze fetch/decode; current instruction not accepted.
- `mem_req`, out, 1: memory request valid.
- `mem_we`, out, 1: request is a write.
- `mem_addr`, out, `ADDR_W`: memory address.
- `mem_wdata`, out, `DATA_W`: memory write data.
- `mem_ack`, in, 1: memory completes the request this cycle. `mem_rdata` is valid with it.
- `mem_rdata`, in, `DATA_W`: memory read data.
- `buf_last`, out, `REG_W`: register receiving buffered load data this cycle. 0 means none.
- `buf_data`, out, `DATA_W`: buffered load data.

## Operation
- States: `IDLE`, `WAIT_LD`, `WAIT_ST`, `WB`.
- An operation is accepted when `op_valid & ~stall_o` in `IDLE` or `WB`. Acceptance behaviour by operation:
  - Load: latch `to_reg` into `pend_reg`, latch the address, go to `WAIT_LD`.
  - Store: latch address and data, go to `WAIT_ST`.
  - `ld_code` `01`/`11` with no store: accepted, no state change; the write is handled downstream.
- `WAIT_LD`:
  - `mem_req = 1`, `mem_we = 0`.
  - On `mem_ack`: capture `mem_rdata` into `buf_data` and `pend_reg` into `buf_last`, go to `WB`.
- `WAIT_ST`:
  - `mem_req = 1`, `mem_we = 1`.
  - On `mem_ack`, go to `IDLE`.
- `WB`:
  - `buf_last`/`buf_data` are valid for exactly this cycle.
  - Next state is the new operation's wait state if one is accepted, else `IDLE`. `buf_last` returns to 0 unless re-loaded.
- `stall_o` is combinational and asserted when any of the following holds:
  - state is `WAIT_LD` or `WAIT_ST`;
  - `op_valid` and state is `WB` and (`rs_a == buf_last` or `rs_b == buf_last`) with `buf_last != 0`;
  - `op_valid` and state is `WB` and `ld_code` is `01`/`11` and `to_reg == buf_last`. This is a write collision: the buffered write has priority downstream, so the new write must wait one cycle.
- A load with `to_reg == 0` still performs the memory read. `buf_last` stays 0, so no write occurs.
- `mem_req` may be held any number of cycles. Address and data are stable until `mem_ack`.
- `mem_ack` is ignored in `IDLE` and `WB`.

## Timing
- Reset values: state `IDLE`; `stall_o`, `mem_req`, `mem_we` = 0; `mem_addr`, `mem_wdata`, `buf_data` = 0; `buf_last` = 0.
- Load accepted at cycle N. `mem_req` rises at N+1.
- Ack at cycle M ≥ N+1 means `buf_last`/`buf_data` are valid at M+1, one cycle only. Minimum load-to-writeback latency is 2 cycles.
- Store accepted at N, ack at M: `stall_o` is low again at M+1.
- Asynchronous reset mid-request drops `mem_req` immediately. A pending load is discarded and no `buf_last` is produced.
- Back-to-back loads: the second load may be accepted in the first load's `WB` cycle if it has no hazard.

## Structure
- Shared package `system_types`:
  - `ld_code` constants `LD_NONE`, `LD_ALU`, `LD_MEM`, `LD_IMM`;
  - `REG_W`, `ADDR_W`, `DATA_W`;
  - state enum `lsb_state_t`.
- One sub-module, `load_hazard_check`: purely combinational. Inputs are state, `buf_last`, `rs_a`, `rs_b`, `to_reg`, `ld_code`, `op_valid`; output is `stall_o`.

## Test plan
- Load `to_reg = 4`, addr `0x0010`, memory acks on the 3rd request cycle with `0xDEADBEEF`:
  - `mem_req` high for 3 cycles, `stall_o` high throughout;
  - next cycle `buf_last = 4`, `buf_data = 0xDEADBEEF` for one cycle, then `buf_last = 0`.
- Store addr `0x0020`, data `0x12345678`, ack after 1 cycle: `mem_we = 1`, `mem_wdata = 0x12345678`, `buf_last` stays 0.
- In `WB` with `buf_last = 7`:
  - next instruction reads `rs_a = 7`: `stall_o = 1` for that cycle, accepted the cycle after;
  - next instruction has `ld_code = 01`, `to_reg = 7`: same result.
- Back-to-back loads to `r3` then `r5` with immediate acks: `buf_last` sequence `3`, then `5` two cycles later. The second load is accepted during `WB` of the first.
- Reset asserted while in `WAIT_LD`: `mem_req` drops without a clock edge. After release: `IDLE`, `buf_last = 0`, and a late `mem_ack` is ignored.
- Load with `to_reg = 0`: one memory read is performed and `buf_last` remains 0.
